hs_spi_slave_axi_m: RTL and testbench

//  Quad-lane SPI slave with an AXI4-Lite master. It is the far-end peer of the hs_spi master:

---
 rtl/hs_spi_slave_axi_m_if.sv | 32 +++
 rtl/hs_spi_slave_axi_m.sv | 210 +++++++++++++++++++++
 tb/tb_hs_spi_slave_axi_m.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hs_spi_slave_axi_m_if.sv
// AXI4-Lite signal bundle: the SPI bridge drives the m side, the addressed target the s side.
interface axi4_lite_if #(
    parameter int AW = 10,
    parameter int DW = 32
);
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wvalid;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;
    logic [AW-1:0]   araddr;
    logic            arvalid;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready;

    modport m (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport s (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/hs_spi_slave_axi_m.sv
// Quad-lane SPI slave: each CSn frame becomes one AXI4-Lite single-beat read or write.
// SCK/CSn/MOSI are oversampled in aclk; there is no second clock domain.
module hs_spi_slave_axi_m #(
    parameter int AW           = 10,
    parameter int DW           = 32,
    parameter int SPI_W        = 4,
    parameter int DUMMY_CYCLES = 4
) (
    input  logic             aclk,
    input  logic             aresetn,
    axi4_lite_if.m           bus_axi,
    input  logic             SCK,
    input  logic             CSn,
    input  logic [SPI_W-1:0] MOSI,
    output logic [SPI_W-1:0] MISO,
    output logic             idle,
    output logic             err,
    input  logic             err_clr
);
    localparam int CMD_N  = 8 / SPI_W;
    localparam int ADDR_N = 16 / SPI_W;
    localparam int DATA_N = DW / SPI_W;
    localparam int SW     = (DW > 16) ? DW : 16;
    localparam int MAX_A  = (DATA_N > ADDR_N) ? DATA_N : ADDR_N;
    localparam int MAX_N  = (MAX_A > DUMMY_CYCLES) ? MAX_A : DUMMY_CYCLES;
    localparam int CW     = $clog2(MAX_N + 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_WDATA, S_DUMMY, S_RDATA, S_DONE} spi_state_t;
    typedef enum logic [2:0] {A_IDLE, A_WR, A_B, A_RD, A_R} axi_state_t;

    logic [1:0]       sck_sync, csn_sync;
    logic [SPI_W-1:0] mosi_meta, mosi_s;
    logic             sck_d, csn_d;
    logic             sck_rise, sck_fall, csn_s, csn_fall;

    spi_state_t       spi_state, spi_next;
    axi_state_t       a_state, a_next;
    logic [CW-1:0]    cnt;
    logic [SW-1:0]    in_sr, in_next;
    logic             is_read;
    logic [AW-1:0]    addr_q, axi_addr;
    logic [DW-1:0]    wdata_q, hold, rd_sr;
    logic             hold_valid, rd_loaded;
    logic             aw_done, w_done;
    logic             wr_req, rd_req, req_drop, resp_err, late;

    // NOTE: every flop uses <= so all registers see pre-edge values, independent of block order.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sck_sync  <= '0;
            csn_sync  <= '1;
            mosi_meta <= '0;
            mosi_s    <= '0;
            sck_d     <= 1'b0;
            csn_d     <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[0], SCK};
            csn_sync  <= {csn_sync[0], CSn};
            mosi_meta <= MOSI;
            mosi_s    <= mosi_meta;
            sck_d     <= sck_sync[1];
            csn_d     <= csn_sync[1];
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_d;
    assign sck_fall = ~sck_sync[1] & sck_d;
    assign csn_s    = csn_sync[1];
    assign csn_fall = ~csn_s & csn_d;
    assign in_next  = {in_sr[SW-SPI_W-1:0], mosi_s};

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        spi_next = spi_state;
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        unique case (spi_state)
            S_IDLE:  if (csn_fall) spi_next = S_CMD;
            S_CMD:   if (sck_rise && cnt == CW'(CMD_N - 1)) spi_next = S_ADDR;
            S_ADDR:  if (sck_rise && cnt == CW'(ADDR_N - 1)) begin
                         spi_next = is_read ? S_DUMMY : S_WDATA;
                         rd_req   = is_read;
                     end
            S_WDATA: if (sck_rise && cnt == CW'(DATA_N - 1)) begin
                         spi_next = S_DONE;
                         wr_req   = 1'b1;
                     end
            S_DUMMY: if (sck_rise && cnt == CW'(DUMMY_CYCLES - 1)) spi_next = S_RDATA;
            S_RDATA: if (sck_rise && cnt == CW'(DATA_N - 1)) spi_next = S_DONE;
            S_DONE:  spi_next = S_DONE;
            default: spi_next = S_IDLE;
        endcase
        if (csn_s) begin
            spi_next = S_IDLE;
            wr_req   = 1'b0;
            rd_req   = 1'b0;
        end
    end

    // NOTE: shift/data registers are not reset; their contents only matter behind a reset valid/state.
    always_ff @(posedge aclk) begin
        if (sck_rise && (spi_state inside {S_CMD, S_ADDR, S_WDATA})) in_sr <= in_next;
        if (spi_state == S_ADDR && spi_next inside {S_DUMMY, S_WDATA}) addr_q <= in_next[AW-1:0];
        if (a_state == A_IDLE && (wr_req || rd_req)) begin
            axi_addr <= wr_req ? addr_q : in_next[AW-1:0];
            wdata_q  <= in_next[DW-1:0];
        end
        if (bus_axi.rvalid && bus_axi.rready) hold <= bus_axi.rdata;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            spi_state <= S_IDLE;
            cnt       <= '0;
            is_read   <= 1'b0;
        end else begin
            spi_state <= spi_next;
            if (spi_next != spi_state) cnt <= '0;
            else if (sck_rise)         cnt <= cnt + CW'(1);
            if (spi_state == S_CMD && spi_next == S_ADDR) is_read <= in_next[7];
        end
    end

    // Read data: first fall in RDATA loads the holding register, later falls shift MSB-first.
    assign late = (spi_state == S_RDATA) && !csn_s && sck_fall && !rd_loaded && !hold_valid;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rd_sr     <= '0;
            rd_loaded <= 1'b0;
        end else if (spi_state != S_RDATA || csn_s) begin
            rd_sr     <= '0;
            rd_loaded <= 1'b0;
        end else if (sck_fall) begin
            rd_loaded <= 1'b1;
            if (rd_loaded)       rd_sr <= {rd_sr[DW-SPI_W-1:0], {SPI_W{1'b0}}};
            else if (hold_valid) rd_sr <= hold;
            else                 rd_sr <= '0;
        end
    end

    assign MISO = rd_sr[DW-1 -: SPI_W];

    always_comb begin
        a_next           = a_state;
        bus_axi.awvalid  = 1'b0;
        bus_axi.wvalid   = 1'b0;
        bus_axi.bready   = 1'b0;
        bus_axi.arvalid  = 1'b0;
        bus_axi.rready   = 1'b0;
        bus_axi.awaddr   = axi_addr;
        bus_axi.araddr   = axi_addr;
        bus_axi.wdata    = wdata_q;
        bus_axi.wstrb    = '1;
        unique case (a_state)
            A_IDLE: begin
                if (wr_req)      a_next = A_WR;
                else if (rd_req) a_next = A_RD;
            end
            A_WR: begin
                bus_axi.awvalid = !aw_done;
                bus_axi.wvalid  = !w_done;
                if ((aw_done || bus_axi.awready) && (w_done || bus_axi.wready)) a_next = A_B;
            end
            A_B: begin
                bus_axi.bready = 1'b1;
                if (bus_axi.bvalid) a_next = A_IDLE;
            end
            A_RD: begin
                bus_axi.arvalid = 1'b1;
                if (bus_axi.arready) a_next = A_R;
            end
            A_R: begin
                bus_axi.rready = 1'b1;
                if (bus_axi.rvalid) a_next = A_IDLE;
            end
            default: a_next = A_IDLE;
        endcase
    end

    assign req_drop = (wr_req || rd_req) && (a_state != A_IDLE);
    assign resp_err = (bus_axi.bvalid && bus_axi.bready && bus_axi.bresp != 2'b00) ||
                      (bus_axi.rvalid && bus_axi.rready && bus_axi.rresp != 2'b00);

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            a_state    <= A_IDLE;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            hold_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            a_state <= a_next;
            if (a_state == A_IDLE) begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end else begin
                if (bus_axi.awvalid && bus_axi.awready) aw_done <= 1'b1;
                if (bus_axi.wvalid && bus_axi.wready)   w_done  <= 1'b1;
            end
            if (bus_axi.rvalid && bus_axi.rready)      hold_valid <= 1'b1;
            else if (a_state == A_IDLE && rd_req)      hold_valid <= 1'b0;
            if (req_drop || resp_err || late) err <= 1'b1;
            else if (err_clr)                 err <= 1'b0;
        end
    end

    assign idle = (spi_state == S_IDLE) && (a_state == A_IDLE) && csn_s;

endmodule

// File: tb/tb_hs_spi_slave_axi_m.sv
// Bench for hs_spi_slave_axi_m: SPI master driver, randomized AXI target, scoreboard queues.
module tb_hs_spi_slave_axi_m;
    localparam int AW       = 10;
    localparam int DW       = 32;
    localparam int DUMMY    = 4;
    localparam int HALF     = 8;
    localparam int LATE_LAT = 100;
    localparam int FULL     = 1000;

    logic       aclk = 1'b0;
    logic       aresetn = 1'b0;
    logic       SCK = 1'b0;
    logic       CSn = 1'b1;
    logic [3:0] MOSI = 4'h0;
    logic [3:0] MISO;
    logic       idle, err;
    logic       err_clr = 1'b0;

    axi4_lite_if #(.AW(AW), .DW(DW)) axi ();

    hs_spi_slave_axi_m #(.AW(AW), .DW(DW), .SPI_W(4), .DUMMY_CYCLES(DUMMY)) dut (
        .aclk(aclk), .aresetn(aresetn), .bus_axi(axi), .SCK(SCK), .CSn(CSn),
        .MOSI(MOSI), .MISO(MISO), .idle(idle), .err(err), .err_clr(err_clr)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct { logic [DW-1:0] data; int lat; logic [1:0] resp; } rsp_t;

    wr_t           exp_wr[$];
    logic [AW-1:0] exp_ar[$];
    logic [DW-1:0] exp_miso[$];
    logic [DW-1:0] obs_miso[$];
    rsp_t          rd_cfg[$];
    logic [1:0]    wr_resp_q[$];
    logic          exp_err = 1'b0;
    bit            stall_aw = 1'b0;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // AXI target: random ready, configurable response latency; compares requests on handshake.
    initial begin : axi_slave
        bit            got_aw, got_w, b_fire, r_fire;
        logic [AW-1:0] aw_a;
        logic [DW-1:0] w_d;
        logic [3:0]    w_s;
        int            b_wait, r_wait;
        rsp_t          cur;
        wr_t           e;
        got_aw = 0; got_w = 0; b_fire = 0; r_fire = 0; b_wait = -1; r_wait = -1;
        axi.awready = 0; axi.wready = 0; axi.arready = 0;
        axi.bvalid = 0; axi.bresp = 0; axi.rvalid = 0; axi.rresp = 0; axi.rdata = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                got_aw = 0; got_w = 0; b_fire = 0; r_fire = 0; b_wait = -1; r_wait = -1;
                axi.awready = 0; axi.wready = 0; axi.arready = 0; axi.bvalid = 0; axi.rvalid = 0;
                continue;
            end
            if (b_fire) begin axi.bvalid = 0; b_fire = 0; end
            if (r_fire) begin axi.rvalid = 0; r_fire = 0; end
            if (b_wait > 0) b_wait--;
            else if (b_wait == 0) begin axi.bvalid = 1; b_wait = -1; end
            if (r_wait > 0) r_wait--;
            else if (r_wait == 0) begin
                axi.rvalid = 1; axi.rdata = cur.data; axi.rresp = cur.resp; r_wait = -1;
            end
            axi.awready = !stall_aw && ($urandom_range(0, 2) != 0);
            axi.wready  = !stall_aw && ($urandom_range(0, 2) != 0);
            axi.arready = ($urandom_range(0, 2) != 0);
            if (axi.awvalid && axi.awready) begin got_aw = 1; aw_a = axi.awaddr; end
            if (axi.wvalid && axi.wready) begin got_w = 1; w_d = axi.wdata; w_s = axi.wstrb; end
            if (got_aw && got_w) begin
                got_aw = 0; got_w = 0;
                check("write_expected", exp_wr.size() != 0, 1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    check("awaddr", aw_a, e.addr);
                    check("wdata", w_d, e.data);
                    check("wstrb", w_s, 4'hF);
                end
                axi.bresp = (wr_resp_q.size() != 0) ? wr_resp_q.pop_front() : 2'b00;
                b_wait = $urandom_range(0, 4);
            end
            if (axi.arvalid && axi.arready) begin
                check("read_expected", exp_ar.size() != 0, 1);
                if (exp_ar.size() != 0) check("araddr", axi.araddr, exp_ar.pop_front());
                if (rd_cfg.size() != 0) cur = rd_cfg.pop_front();
                else begin cur.data = '0; cur.lat = 0; cur.resp = 2'b00; end
                r_wait = cur.lat;
            end
            b_fire = axi.bvalid && axi.bready;
            r_fire = axi.rvalid && axi.rready;
        end
    end

    initial begin : miso_monitor
        forever begin
            @(negedge aclk);
            while (obs_miso.size() != 0) begin
                check("miso_expected", exp_miso.size() != 0, 1);
                if (exp_miso.size() != 0) check("miso_word", obs_miso.pop_front(), exp_miso.pop_front());
                else obs_miso.delete(0);
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog");
    end

    task automatic spi_clk(input logic [3:0] out, output logic [3:0] in);
        MOSI = out;
        repeat (HALF) @(negedge aclk);
        in  = MISO;
        SCK = 1'b1;
        repeat (HALF) @(negedge aclk);
        SCK = 1'b0;
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input logic [15:0] a, input logic [DW-1:0] d,
                             input int max_clks, input bit keep_low);
        logic [3:0]    nib;
        logic [DW-1:0] rd_word;
        int            n;
        n = 0; rd_word = '0;
        CSn = 1'b0;
        for (int i = 0; i < 2; i++) if (n < max_clks) begin spi_clk(cmd[7-4*i -: 4], nib); n++; end
        for (int i = 0; i < 4; i++) if (n < max_clks) begin spi_clk(a[15-4*i -: 4], nib); n++; end
        if (!cmd[7]) begin
            for (int i = 0; i < DW/4; i++)
                if (n < max_clks) begin spi_clk(d[DW-1-4*i -: 4], nib); n++; end
        end else begin
            for (int i = 0; i < DUMMY; i++) if (n < max_clks) begin spi_clk(4'h0, nib); n++; end
            for (int i = 0; i < DW/4; i++)
                if (n < max_clks) begin
                    spi_clk(4'h0, nib);
                    rd_word = {rd_word[DW-5:0], nib};
                    n++;
                end
            if (n == 6 + DUMMY + DW/4) obs_miso.push_back(rd_word);
        end
        repeat (HALF) @(negedge aclk);
        MOSI = 4'h0;
        if (!keep_low) begin
            CSn = 1'b1;
            repeat (6) @(negedge aclk);
        end
    endtask

    task automatic wait_idle(input string name);
        int t, stable;
        t = 0; stable = 0;
        while (stable < 3 && t < 3000) begin
            @(negedge aclk);
            t++;
            stable = idle ? stable + 1 : 0;
        end
        check({name, "_idle"}, idle, 1);
    endtask

    task automatic pulse_clr();
        @(negedge aclk); err_clr = 1'b1;
        @(negedge aclk); err_clr = 1'b0;
        exp_err = 1'b0;
        @(negedge aclk);
        check("err_cleared", err, 0);
    endtask

    // Reference model: a completed write frame yields one AXI write of addr[AW-1:0]/data;
    // a read frame yields one AXI read, and MISO carries rdata unless it arrives after the dummies.
    task automatic do_write(input logic [15:0] a, input logic [DW-1:0] d, input logic [1:0] resp,
                            input logic [6:0] low);
        wr_t e;
        e.addr = a[AW-1:0]; e.data = d;
        exp_wr.push_back(e);
        wr_resp_q.push_back(resp);
        if (resp != 2'b00) exp_err = 1'b1;
        spi_frame({1'b0, low}, a, d, FULL, 1'b0);
        wait_idle("write");
        check("err_after_write", err, exp_err);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [DW-1:0] d, input int lat,
                           input logic [1:0] resp, input logic [6:0] low);
        rsp_t c;
        c.data = d; c.lat = lat; c.resp = resp;
        rd_cfg.push_back(c);
        exp_ar.push_back(a[AW-1:0]);
        exp_miso.push_back((lat >= LATE_LAT) ? '0 : d);
        if (lat >= LATE_LAT || resp != 2'b00) exp_err = 1'b1;
        spi_frame({1'b1, low}, a, '0, FULL, 1'b0);
        wait_idle("read");
        check("err_after_read", err, exp_err);
    endtask

    initial begin : stimulus
        logic [15:0]   a;
        logic [DW-1:0] d;
        logic [1:0]    resp;
        int            kind, lat;
        wr_t           e;

        repeat (4) @(negedge aclk);
        check("rst_miso", MISO, 0);
        check("rst_idle", idle, 1);
        check("rst_err", err, 0);
        check("rst_awvalid", axi.awvalid, 0);
        check("rst_wvalid", axi.wvalid, 0);
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_bready", axi.bready, 0);
        check("rst_rready", axi.rready, 0);
        aresetn = 1'b1;
        repeat (4) @(negedge aclk);

        do_write(16'h0123, 32'hDEADBEEF, 2'b00, 7'h00);
        do_read(16'h0040, 32'h12345678, 3, 2'b00, 7'h00);

        do_read(16'h0155, 32'hCAFEF00D, 140, 2'b00, 7'h00);
        check("late_err_set", err, 1);
        pulse_clr();

        spi_frame(8'h00, 16'h0200, 32'h11223344, 2 + 4 + 3, 1'b0);
        wait_idle("abort_write");
        check("abort_awvalid", axi.awvalid, 0);
        check("abort_err", err, 0);

        stall_aw = 1'b1;
        e.addr = 10'h2A5; e.data = 32'hA5A5_0001;
        exp_wr.push_back(e);
        wr_resp_q.push_back(2'b00);
        spi_frame(8'h00, 16'h02A5, 32'hA5A5_0001, FULL, 1'b0);
        spi_frame(8'h00, 16'h0066, 32'h5A5A_0002, FULL, 1'b0);
        exp_err = 1'b1;
        repeat (20) @(negedge aclk);
        check("stall_awvalid_held", axi.awvalid, 1);
        stall_aw = 1'b0;
        wait_idle("stall");
        check("drop_err", err, exp_err);
        pulse_clr();

        rd_cfg.push_back('{data: 32'hA5A5A5A5, lat: 5, resp: 2'b00});
        exp_ar.push_back(10'h0F0);
        spi_frame(8'h80, 16'h00F0, '0, 6 + DUMMY + 3, 1'b1);
        @(negedge aclk); aresetn = 1'b0;
        @(negedge aclk);
        check("midrst_miso", MISO, 0);
        check("midrst_arvalid", axi.arvalid, 0);
        check("midrst_idle", idle, 1);
        CSn = 1'b1;
        exp_err = 1'b0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        repeat (4) @(negedge aclk);
        do_write(16'h0311, 32'h0BADCAFE, 2'b00, 7'h15);
        do_read(16'h0311, 32'h76543210, 7, 2'b00, 7'h2A);

        for (int k = 0; k < 24; k++) begin
            kind = $urandom_range(0, 9);
            a    = 16'($urandom);
            d    = $urandom;
            resp = ($urandom_range(0, 4) == 0) ? 2'b10 : 2'b00;
            if (kind < 4) begin
                do_write(a, d, resp, 7'($urandom));
            end else if (kind < 8) begin
                lat = ($urandom_range(0, 4) == 0) ? $urandom_range(110, 150) : $urandom_range(0, 20);
                do_read(a, d, lat, resp, 7'($urandom));
            end else begin
                spi_frame({1'b0, 7'($urandom)}, a, d, $urandom_range(6, 13), 1'b0);
                wait_idle("rand_abort");
                check("rand_abort_err", err, exp_err);
            end
            if ($urandom_range(0, 3) == 0) pulse_clr();
        end

        repeat (20) @(negedge aclk);
        check("pending_writes", exp_wr.size(), 0);
        check("pending_reads", exp_ar.size(), 0);
        check("pending_miso", exp_miso.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
